// File: rtl/sprite_line_scheduler_pkg.sv
// Shared constants, state encoding and line arithmetic for the sprite line scheduler.
package sprite_line_scheduler_pkg;

    localparam int NUM_SPRITES = 16;
    localparam int NUM_SLOTS   = 4;
    localparam int SPRITE_H    = 16;
    localparam int V_TOTAL     = 267;

    localparam logic [8:0] H_DISPLAY_DEFAULT = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    // Line that will be displayed after the current one; wraps at the frame end.
    function automatic logic [8:0] next_line(input logic [8:0] vpos);
        logic [8:0] t;
        if (vpos == 9'(V_TOTAL - 1)) begin
            t = 9'd0;
        end else begin
            t = vpos + 9'd1;
        end
        return t;
    endfunction

    // Distance from the sprite top to the target line, modulo the 9-bit line space.
    function automatic logic [8:0] line_delta(input logic [8:0] t, input logic [8:0] y);
        return t - y;
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_y_table.sv
// 16-entry sprite Y table: {en, y[8:0]} per entry, sync write, async read.
module sprite_y_table
    import sprite_line_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [9:0] wdata,
    input  logic [3:0] raddr,
    output logic [9:0] rdata
);

    logic [9:0] mem_r [NUM_SPRITES];

    // Table storage: cleared on reset, one entry written per cycle on we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                mem_r[k] <= 10'd0;
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // A read in the same cycle as a write to that entry sees the old contents.
    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the Y table during horizontal blanking
// and hands up to NUM_SLOTS hitting sprites to the renderer slots.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter logic [8:0] H_DISPLAY = H_DISPLAY_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       cfg_we,
    input  logic [3:0] cfg_addr,
    input  logic [8:0] cfg_y,
    input  logic       cfg_en,
    output logic       load_valid,
    input  logic       load_ready,
    output logic [1:0] load_slot,
    output logic [3:0] load_index,
    output logic [3:0] load_row,
    output logic [3:0] slot_active,
    output logic       overflow,
    output logic       late,
    output logic       busy
);

    sched_state_t state_r, state_nx_s;

    logic [3:0] idx_r,         idx_nx_s;
    logic [2:0] count_r,       count_nx_s;
    logic [8:0] target_r,      target_nx_s;
    logic       load_valid_r,  load_valid_nx_s;
    logic [1:0] load_slot_r,   load_slot_nx_s;
    logic [3:0] load_index_r,  load_index_nx_s;
    logic [3:0] load_row_r,    load_row_nx_s;
    logic [3:0] slot_active_r, slot_active_nx_s;
    logic       overflow_r,    overflow_nx_s;
    logic       late_r,        late_nx_s;
    logic       busy_r,        busy_nx_s;

    logic [9:0] entry_s;
    logic [8:0] delta_s;
    logic       hit_s;
    logic       trigger_s;
    logic       last_idx_s;
    logic       handshake_s;
    logic       slots_left_s;

    sprite_y_table u_table (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata ({cfg_en, cfg_y}),
        .raddr (idx_r),
        .rdata (entry_s)
    );

    // Hit arithmetic is modulo 512 so sprites straddling line 511/0 still hit.
    assign delta_s      = line_delta(target_r, entry_s[8:0]);
    assign hit_s        = entry_s[9] && (delta_s < 9'(SPRITE_H));
    assign trigger_s    = (hpos == H_DISPLAY);
    assign last_idx_s   = (idx_r == 4'(NUM_SPRITES - 1));
    assign handshake_s  = load_valid_r && load_ready;
    assign slots_left_s = (count_r < 3'(NUM_SLOTS));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; the end-of-line abort is only honoured while scanning.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    state_nx_s = ST_SCAN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (hpos == 9'd0) begin
                    state_nx_s = ST_DONE;
                end else if (hit_s) begin
                    if (slots_left_s) begin
                        state_nx_s = ST_LOAD;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else if (last_idx_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_SCAN;
                end
            end
            ST_LOAD: begin
                if (handshake_s) begin
                    if (last_idx_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_SCAN;
                    end
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; the load payload only changes when a load is issued.
    always_comb begin
        idx_nx_s         = idx_r;
        count_nx_s       = count_r;
        target_nx_s      = target_r;
        load_valid_nx_s  = load_valid_r;
        load_slot_nx_s   = load_slot_r;
        load_index_nx_s  = load_index_r;
        load_row_nx_s    = load_row_r;
        slot_active_nx_s = slot_active_r;
        overflow_nx_s    = overflow_r;
        late_nx_s        = late_r;
        case (state_r)
            ST_IDLE: begin
                if (trigger_s) begin
                    idx_nx_s         = 4'd0;
                    count_nx_s       = 3'd0;
                    target_nx_s      = next_line(vpos);
                    slot_active_nx_s = 4'd0;
                    overflow_nx_s    = 1'b0;
                    late_nx_s        = 1'b0;
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_SCAN: begin
                if (hpos == 9'd0) begin
                    late_nx_s = 1'b1;
                end else if (hit_s) begin
                    if (slots_left_s) begin
                        load_valid_nx_s = 1'b1;
                        load_slot_nx_s  = count_r[1:0];
                        load_index_nx_s = idx_r;
                        load_row_nx_s   = delta_s[3:0];
                    end else begin
                        overflow_nx_s = 1'b1;
                    end
                end else if (!last_idx_s) begin
                    idx_nx_s = idx_r + 4'd1;
                end else begin
                    idx_nx_s = idx_r;
                end
            end
            ST_LOAD: begin
                if (handshake_s) begin
                    slot_active_nx_s[count_r[1:0]] = 1'b1;
                    count_nx_s      = count_r + 3'd1;
                    load_valid_nx_s = 1'b0;
                    if (!last_idx_s) begin
                        idx_nx_s = idx_r + 4'd1;
                    end else begin
                        idx_nx_s = idx_r;
                    end
                end else begin
                    load_valid_nx_s = load_valid_r;
                end
            end
            ST_DONE: begin
                load_valid_nx_s = 1'b0;
            end
            default: begin
                load_valid_nx_s = 1'b0;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r         <= 4'd0;
            count_r       <= 3'd0;
            target_r      <= 9'd0;
            load_valid_r  <= 1'b0;
            load_slot_r   <= 2'd0;
            load_index_r  <= 4'd0;
            load_row_r    <= 4'd0;
            slot_active_r <= 4'd0;
            overflow_r    <= 1'b0;
            late_r        <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            idx_r         <= idx_nx_s;
            count_r       <= count_nx_s;
            target_r      <= target_nx_s;
            load_valid_r  <= load_valid_nx_s;
            load_slot_r   <= load_slot_nx_s;
            load_index_r  <= load_index_nx_s;
            load_row_r    <= load_row_nx_s;
            slot_active_r <= slot_active_nx_s;
            overflow_r    <= overflow_nx_s;
            late_r        <= late_nx_s;
            busy_r        <= busy_nx_s;
        end
    end

    assign load_valid  = load_valid_r;
    assign load_slot   = load_slot_r;
    assign load_index  = load_index_r;
    assign load_row    = load_row_r;
    assign slot_active = slot_active_r;
    assign overflow    = overflow_r;
    assign late        = late_r;
    assign busy        = busy_r;

endmodule
